// File: rtl/pkt_monitor512_pkg.sv
// Shared types and helpers for the pkt_monitor512 stream sink.
package pkt_mon_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          MAX_FOLD_W   = 1024;

  typedef enum logic {IDLE, IN_PKT} state_t;

  function automatic int calc_empty_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Narrower streams are zero-extended by the caller; zero words leave the XOR unchanged.
  function automatic logic [31:0] fold32(input logic [MAX_FOLD_W-1:0] data);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_FOLD_W / 32; i++) begin
      acc = acc ^ data[i*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/pkt_monitor512_lfsr.sv
// Seeded pseudo-random backpressure: registered ready from a 16-bit Fibonacci LFSR.
module lfsr_ready_gen
  import pkt_mon_pkg::*;
#(
  parameter logic [15:0] SEED       = DEFAULT_SEED,
  parameter int          READY_RATE = 256
) (
  input  logic clk,
  input  logic reset,
  output logic o_ready
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? DEFAULT_SEED : SEED;
  // A threshold of 256 exceeds every 8-bit sample, so full rate needs no special case.
  localparam logic [8:0]  RATE9    = (READY_RATE >= 256) ? 9'd256 :
                                     (READY_RATE <= 0)   ? 9'd0   : 9'(READY_RATE);

  logic [15:0] r_lfsr;
  logic        r_ready;
  logic        w_feedback;

  assign w_feedback = ^(r_lfsr & LFSR_TAPS);
  assign o_ready    = r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= SEED_EFF;
      r_ready <= 1'b0;
    end else begin
      r_lfsr  <= {w_feedback, r_lfsr[15:1]};
      r_ready <= ({1'b0, r_lfsr[7:0]} < RATE9);
    end
  end

endmodule

// File: rtl/pkt_monitor512.sv
// Terminal Avalon-ST sink: framing checks, packet/byte counters and a rolling payload signature.
module pkt_monitor512
  import pkt_mon_pkg::*;
#(
  parameter  int          DATA_WIDTH    = 512,
  parameter  int          EXPECTED_PKTS = 0,
  parameter  int          READY_RATE    = 256,
  parameter  logic [15:0] SEED          = 16'hACE1,
  parameter  int          MAX_PKT_BYTES = 9600,
  localparam int          EMPTY_W       = calc_empty_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sop,
  input  logic                  i_eop,
  input  logic [EMPTY_W-1:0]    i_empty,
  output logic                  o_ready,
  output logic [31:0]           o_pkt_count,
  output logic [31:0]           o_byte_count,
  output logic [15:0]           o_last_len,
  output logic [15:0]           o_err_no_sop,
  output logic [15:0]           o_err_no_eop,
  output logic [15:0]           o_err_empty,
  output logic [15:0]           o_err_oversize,
  output logic [31:0]           o_signature,
  output logic                  o_finished
);

  localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);
  localparam logic [31:0] MAX_LEN    = 32'(MAX_PKT_BYTES);
  localparam logic [31:0] EXP_CNT    = 32'(EXPECTED_PKTS);

  state_t                r_state;
  logic [31:0]           r_len;
  logic [31:0]           r_pktCount;
  logic [31:0]           r_byteCount;
  logic [15:0]           r_lastLen;
  logic [15:0]           r_errNoSop;
  logic [15:0]           r_errNoEop;
  logic [15:0]           r_errEmpty;
  logic [15:0]           r_errOversize;
  logic [31:0]           r_signature;
  logic                  r_finished;

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_abort;
  logic                  w_complete;
  logic                  w_good;
  logic                  w_oversize;
  logic                  w_emptyErr;
  logic [31:0]           w_beatBytes;
  logic [32:0]           w_lenSum33;
  logic [31:0]           w_lenSum;
  logic [31:0]           w_finalLen;
  logic [32:0]           w_byteSum33;
  logic [31:0]           w_byteNext;
  logic [31:0]           w_pktNext;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [31:0]           w_fold;
  state_t                w_nextState;
  logic [31:0]           w_nextLen;

  lfsr_ready_gen #(
    .SEED       (SEED),
    .READY_RATE (READY_RATE)
  ) u_ready_gen (
    .clk     (clk),
    .reset   (reset),
    .o_ready (w_ready)
  );

  always_comb begin
    w_accept    = i_valid && w_ready;
    w_beatBytes = i_eop ? (BEAT_BYTES - 32'(i_empty)) : BEAT_BYTES;
    w_lenSum33  = {1'b0, r_len} + {1'b0, w_beatBytes};
    w_lenSum    = w_lenSum33[32] ? '1 : w_lenSum33[31:0];
    w_finalLen  = i_sop ? w_beatBytes : w_lenSum;
    w_drop      = w_accept && (r_state == IDLE) && !i_sop;
    w_abort     = w_accept && (r_state == IN_PKT) && i_sop;
    w_complete  = w_accept && i_eop && (i_sop || (r_state == IN_PKT));
    w_oversize  = w_complete && (w_finalLen > MAX_LEN);
    w_good      = w_complete && !(w_finalLen > MAX_LEN);
    w_emptyErr  = w_accept && !i_eop && (i_empty != '0);
    w_byteSum33 = {1'b0, r_byteCount} + {1'b0, w_finalLen};
    w_byteNext  = w_byteSum33[32] ? '1 : w_byteSum33[31:0];
    w_pktNext   = r_pktCount + {31'b0, (r_pktCount != '1)};
    w_mask      = i_eop ? ({DATA_WIDTH{1'b1}} << {i_empty, 3'b000}) : {DATA_WIDTH{1'b1}};
    w_fold      = fold32(MAX_FOLD_W'(i_data & w_mask));

    w_nextState = r_state;
    w_nextLen   = r_len;
    if (w_accept && !w_drop) begin
      // An SOP always restarts the accumulator, whether or not a packet was open.
      w_nextState = i_eop ? IDLE : IN_PKT;
      w_nextLen   = i_eop ? 32'd0 : w_finalLen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_pktCount    <= '0;
      r_byteCount   <= '0;
      r_lastLen     <= '0;
      r_errNoSop    <= '0;
      r_errNoEop    <= '0;
      r_errEmpty    <= '0;
      r_errOversize <= '0;
      r_signature   <= '0;
      r_finished    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_len   <= w_nextLen;
      if (w_accept && !w_drop) begin
        r_signature <= {r_signature[30:0], r_signature[31]} ^ w_fold;
      end
      if (w_drop) begin
        r_errNoSop <= r_errNoSop + {15'b0, (r_errNoSop != '1)};
      end
      if (w_abort) begin
        r_errNoEop <= r_errNoEop + {15'b0, (r_errNoEop != '1)};
      end
      if (w_emptyErr) begin
        r_errEmpty <= r_errEmpty + {15'b0, (r_errEmpty != '1)};
      end
      if (w_oversize) begin
        r_errOversize <= r_errOversize + {15'b0, (r_errOversize != '1)};
      end
      if (w_good) begin
        r_pktCount  <= w_pktNext;
        r_byteCount <= w_byteNext;
        r_lastLen   <= w_finalLen[15:0];
        if ((EXP_CNT != 32'd0) && (w_pktNext == EXP_CNT)) begin
          r_finished <= 1'b1;
        end
      end
    end
  end

  assign o_ready        = w_ready;
  assign o_pkt_count    = r_pktCount;
  assign o_byte_count   = r_byteCount;
  assign o_last_len     = r_lastLen;
  assign o_err_no_sop   = r_errNoSop;
  assign o_err_no_eop   = r_errNoEop;
  assign o_err_empty    = r_errEmpty;
  assign o_err_oversize = r_errOversize;
  assign o_signature    = r_signature;
  assign o_finished     = r_finished;

endmodule

// File: tb/tb_pkt_monitor512.sv
// Directed bench for pkt_monitor512: framing, counters, signature and randomized backpressure.
module tb_pkt_monitor512;

  logic         clk;
  logic         reset;

  logic         valid;
  logic [511:0] data;
  logic         sop;
  logic         eop;
  logic [5:0]   empty;
  logic         ready;
  logic [31:0]  pktCount;
  logic [31:0]  byteCount;
  logic [15:0]  lastLen;
  logic [15:0]  errNoSop;
  logic [15:0]  errNoEop;
  logic [15:0]  errEmpty;
  logic [15:0]  errOversize;
  logic [31:0]  signature;
  logic         finished;

  logic         valid2;
  logic         ready2;
  logic [31:0]  pktCount2;
  logic [31:0]  byteCount2;
  logic [15:0]  lastLen2;
  logic [15:0]  errNoSop2;
  logic [15:0]  errNoEop2;
  logic [15:0]  errEmpty2;
  logic [15:0]  errOversize2;
  logic [31:0]  signature2;
  logic         finished2;

  int vectors;
  int miscompares;

  pkt_monitor512 #(
    .DATA_WIDTH    (512),
    .EXPECTED_PKTS (0),
    .READY_RATE    (256),
    .SEED          (16'hACE1),
    .MAX_PKT_BYTES (9600)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_valid        (valid),
    .i_data         (data),
    .i_sop          (sop),
    .i_eop          (eop),
    .i_empty        (empty),
    .o_ready        (ready),
    .o_pkt_count    (pktCount),
    .o_byte_count   (byteCount),
    .o_last_len     (lastLen),
    .o_err_no_sop   (errNoSop),
    .o_err_no_eop   (errNoEop),
    .o_err_empty    (errEmpty),
    .o_err_oversize (errOversize),
    .o_signature    (signature),
    .o_finished     (finished)
  );

  pkt_monitor512 #(
    .DATA_WIDTH    (512),
    .EXPECTED_PKTS (10),
    .READY_RATE    (64),
    .SEED          (16'h0001),
    .MAX_PKT_BYTES (9600)
  ) dut2 (
    .clk            (clk),
    .reset          (reset),
    .i_valid        (valid2),
    .i_data         ('0),
    .i_sop          (1'b1),
    .i_eop          (1'b1),
    .i_empty        (6'd0),
    .o_ready        (ready2),
    .o_pkt_count    (pktCount2),
    .o_byte_count   (byteCount2),
    .o_last_len     (lastLen2),
    .o_err_no_sop   (errNoSop2),
    .o_err_no_eop   (errNoEop2),
    .o_err_empty    (errEmpty2),
    .o_err_oversize (errOversize2),
    .o_signature    (signature2),
    .o_finished     (finished2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    empty = '0;
    data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [5:0] emp, input logic [511:0] d);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    vectors++;
    if (waitCycles >= 50) begin
      miscompares++;
      $display("[TB] FAIL ready_timeout: waited %0d cycles, required ready within 50", waitCycles);
    end
    valid = 1'b1;
    sop   = s;
    eop   = e;
    empty = emp;
    data  = d;
    @(posedge clk);
    #1;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    empty = '0;
    data  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    valid2 = 1'b0;
    sop = 1'b0; eop = 1'b0; empty = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: got %0b, expected 0", ready);
    end
    vectors++;
    if ({pktCount, byteCount, lastLen, errNoSop, errNoEop, errEmpty, errOversize, signature, finished} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: pkt %0d bytes %0d len %0d sig %h fin %0b, expected all 0",
               pktCount, byteCount, lastLen, signature, finished);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset: got %0b, expected 1", ready);
    end
  endtask

  task automatic test_three_beat();
    logic [511:0] d;
    do_reset();
    send_beat(1'b1, 1'b0, 6'd0, '0);
    send_beat(1'b0, 1'b0, 6'd0, '0);
    d = '0;
    d[31:0]  = 32'hFFFF_FFFF;
    d[63:32] = 32'h0000_0010;
    send_beat(1'b0, 1'b1, 6'd4, d);
    vectors++;
    if (pktCount !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL three_pkt_count: got %0d, expected 1", pktCount);
    end
    vectors++;
    if (byteCount !== 32'd188) begin
      miscompares++;
      $display("[TB] FAIL three_byte_count: got %0d, expected 188", byteCount);
    end
    vectors++;
    if (lastLen !== 16'd188) begin
      miscompares++;
      $display("[TB] FAIL three_last_len: got %0d, expected 188", lastLen);
    end
    vectors++;
    if ({errNoSop, errNoEop, errEmpty, errOversize} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL three_errors: got %0d/%0d/%0d/%0d, expected 0/0/0/0",
               errNoSop, errNoEop, errEmpty, errOversize);
    end
    vectors++;
    if (signature !== 32'h0000_0010) begin
      miscompares++;
      $display("[TB] FAIL three_signature_mask: got %h, expected 00000010", signature);
    end
  endtask

  task automatic test_single_beat();
    logic [511:0] d;
    do_reset();
    d = '0;
    d[511:504] = 8'hAB;
    send_beat(1'b1, 1'b1, 6'd63, d);
    vectors++;
    if (byteCount !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL single_byte_count: got %0d, expected 1", byteCount);
    end
    vectors++;
    if (lastLen !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL single_last_len: got %0d, expected 1", lastLen);
    end
    vectors++;
    if (signature !== 32'hAB00_0000) begin
      miscompares++;
      $display("[TB] FAIL single_signature: got %h, expected ab000000", signature);
    end
  endtask

  task automatic test_no_sop();
    logic [511:0] d;
    do_reset();
    send_beat(1'b0, 1'b0, 6'd0, {16{32'h1234_5678}});
    d = '0;
    d[31:0] = 32'h1;
    send_beat(1'b1, 1'b0, 6'd0, d);
    send_beat(1'b0, 1'b1, 6'd0, d);
    vectors++;
    if (errNoSop !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL nosop_err: got %0d, expected 1", errNoSop);
    end
    vectors++;
    if (pktCount !== 32'd1 || byteCount !== 32'd128) begin
      miscompares++;
      $display("[TB] FAIL nosop_counts: pkt %0d bytes %0d, expected pkt 1 bytes 128", pktCount, byteCount);
    end
    vectors++;
    if (signature !== 32'h0000_0003) begin
      miscompares++;
      $display("[TB] FAIL nosop_signature: got %h, expected 00000003", signature);
    end
  endtask

  task automatic test_no_eop();
    do_reset();
    send_beat(1'b1, 1'b0, 6'd0, '0);
    send_beat(1'b0, 1'b0, 6'd0, '0);
    send_beat(1'b1, 1'b1, 6'd0, '0);
    vectors++;
    if (errNoEop !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL noeop_err: got %0d, expected 1", errNoEop);
    end
    vectors++;
    if (pktCount !== 32'd1 || lastLen !== 16'd64 || byteCount !== 32'd64) begin
      miscompares++;
      $display("[TB] FAIL noeop_counts: pkt %0d len %0d bytes %0d, expected 1/64/64", pktCount, lastLen, byteCount);
    end
  endtask

  task automatic test_empty_err();
    do_reset();
    send_beat(1'b1, 1'b0, 6'd5, '0);
    send_beat(1'b0, 1'b1, 6'd0, '0);
    vectors++;
    if (errEmpty !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL empty_err: got %0d, expected 1", errEmpty);
    end
    vectors++;
    if (lastLen !== 16'd128) begin
      miscompares++;
      $display("[TB] FAIL empty_full_bytes: got %0d, expected 128", lastLen);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_beat(1'b1, 1'b0, 6'd0, '0);
    for (int i = 0; i < 149; i++) send_beat(1'b0, 1'b0, 6'd0, '0);
    send_beat(1'b0, 1'b1, 6'd0, '0);
    vectors++;
    if (errOversize !== 16'd1 || pktCount !== 32'd0 || byteCount !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL oversize_9664: err %0d pkt %0d bytes %0d, expected 1/0/0", errOversize, pktCount, byteCount);
    end
    send_beat(1'b1, 1'b0, 6'd0, '0);
    for (int i = 0; i < 148; i++) send_beat(1'b0, 1'b0, 6'd0, '0);
    send_beat(1'b0, 1'b1, 6'd0, '0);
    vectors++;
    if (errOversize !== 16'd1 || pktCount !== 32'd1 || byteCount !== 32'd9600 || lastLen !== 16'd9600) begin
      miscompares++;
      $display("[TB] FAIL oversize_limit_9600: err %0d pkt %0d bytes %0d len %0d, expected 1/1/9600/9600",
               errOversize, pktCount, byteCount, lastLen);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(posedge clk);
    @(negedge clk);
    valid = 1'b1;
    sop   = 1'b1;
    eop   = 1'b1;
    empty = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    valid = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    vectors++;
    if (pktCount !== 32'd3 || byteCount !== 32'd192) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: pkt %0d bytes %0d, expected 3/192", pktCount, byteCount);
    end
  endtask

  task automatic test_reset_mid_pkt();
    do_reset();
    send_beat(1'b1, 1'b0, 6'd0, {16{32'hDEAD_BEEF}});
    send_beat(1'b0, 1'b0, 6'd0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({pktCount, byteCount, errNoSop, errNoEop, errEmpty, errOversize, signature} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_clear: pkt %0d bytes %0d noeop %0d sig %h, expected all 0",
               pktCount, byteCount, errNoEop, signature);
    end
    @(negedge clk);
    reset = 1'b0;
    send_beat(1'b1, 1'b1, 6'd0, '0);
    vectors++;
    if (pktCount !== 32'd1 || lastLen !== 16'd64) begin
      miscompares++;
      $display("[TB] FAIL midreset_pkt: pkt %0d len %0d, expected 1/64", pktCount, lastLen);
    end
    vectors++;
    if ({errNoSop, errNoEop, errEmpty, errOversize} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_errors: got %0d/%0d/%0d/%0d, expected 0/0/0/0",
               errNoSop, errNoEop, errEmpty, errOversize);
    end
  endtask

  task automatic test_ready_rate();
    int accepted;
    int readyHigh;
    do_reset();
    accepted  = 0;
    readyHigh = 0;
    valid2 = 1'b1;
    for (int cyc = 0; cyc < 4096; cyc++) begin
      @(negedge clk);
      vectors++;
      if (pktCount2 !== 32'(accepted)) begin
        miscompares++;
        $display("[TB] FAIL rate_pkt_count cycle %0d: got %0d, expected %0d", cyc, pktCount2, accepted);
      end
      vectors++;
      if (finished2 !== (accepted >= 10)) begin
        miscompares++;
        $display("[TB] FAIL rate_finished cycle %0d: got %0b, expected %0b", cyc, finished2, (accepted >= 10));
      end
      if (ready2 === 1'b1) begin
        readyHigh++;
        accepted++;
      end
    end
    valid2 = 1'b0;
    vectors++;
    if (readyHigh < 717 || readyHigh > 1331) begin
      miscompares++;
      $display("[TB] FAIL rate_duty: ready high %0d of 4096, expected about 1024", readyHigh);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    valid2      = 1'b0;
    test_reset();
    test_three_beat();
    test_single_beat();
    test_no_sop();
    test_no_eop();
    test_empty_err();
    test_oversize();
    test_back_to_back();
    test_reset_mid_pkt();
    test_ready_rate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pkt_monitor512.md
Name: pkt_monitor512

Overview:
- Terminal Avalon-ST sink that consumes a 512-bit packet stream (SOP/EOP/empty framing) at the egress end of the NoC packet path.
- It is the consuming counterpart to the pcap packet reader.
- Applies seeded pseudo-random backpressure, checks framing, and counts packets and bytes.
- Folds payload into a 32-bit signature for end-to-end comparison and asserts finished after an expected packet count.

Parameters:
- DATA_WIDTH, 512, stream width in bits; multiple of 64. EMPTY_W = $clog2(DATA_WIDTH/8).
- EXPECTED_PKTS, 0, good-packet count that raises o_finished; 0 disables.
- READY_RATE, 256, ready probability in 1/256 units; 256 means always ready.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.
- MAX_PKT_BYTES, 9600, larger packets are flagged oversize.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- i_valid  in  1  beat valid.
- i_data  in  DATA_WIDTH  beat data; byte 0 at the MSB.
- i_sop  in  1  start of packet.
- i_eop  in  1  end of packet.
- i_empty  in  EMPTY_W  unused low-order bytes; meaningful only on EOP beats.
- o_ready  out  1  sink ready (registered).
- o_pkt_count  out  32  good packets received.
- o_byte_count  out  32  bytes in good packets.
- o_last_len  out  16  length of the last good packet.
- o_err_no_sop  out  16  beats dropped outside a packet.
- o_err_no_eop  out  16  packets aborted by a new SOP.
- o_err_empty  out  16  non-EOP beats with nonzero empty.
- o_err_oversize  out  16  packets exceeding MAX_PKT_BYTES.
- o_signature  out  32  running payload signature.
- o_finished  out  1  sticky completion flag.

Behaviour:
- Reset: all outputs 0, o_ready 0, state IDLE, length accumulator 0, LFSR = SEED. Reset mid-packet discards the partial packet; no error is counted.
- Acceptance: a beat is accepted when i_valid && o_ready at a rising edge. Inputs are ignored otherwise.
- Ready generation:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle.
  - o_ready <= (READY_RATE >= 256) || (lfsr[7:0] < READY_RATE).
  - o_ready is independent of i_valid. READY_RATE 0 keeps o_ready at 0.
- Beat byte count: DATA_WIDTH/8 on non-EOP beats; DATA_WIDTH/8 - i_empty on EOP beats.
- States:
  - IDLE:
    - sop&eop: single-beat packet; complete it, stay IDLE.
    - sop&!eop: len <= beat bytes; go to IN_PKT.
    - !sop: increment err_no_sop, drop the beat, stay IDLE.
  - IN_PKT:
    - !sop&!eop: len += beat bytes.
    - !sop&eop: complete the packet, go to IDLE.
    - sop: increment err_no_eop, discard the accumulated length, and treat the beat as a fresh SOP per the IDLE rules.
- Empty check: a nonzero i_empty on any accepted non-EOP beat increments err_empty. The beat is still used, with full byte count.
- Packet completion:
  - If the final length > MAX_PKT_BYTES: increment err_oversize; counts and o_last_len are unchanged.
  - Otherwise: pkt_count++, byte_count += len, o_last_len <= len.
- Signature:
  - Updated on every accepted beat that is not dropped, including beats of aborted or oversize packets.
  - Mask: on EOP beats, zero the low i_empty*8 bits.
  - sig <= {sig[30:0],sig[31]} ^ XOR of all 32-bit words of the masked data.
- Counters: all saturate at all-ones; no wrap.
- Timing: every counter and the signature are registered and visible the cycle after the accepting edge.
- o_finished: set on the cycle pkt_count becomes EXPECTED_PKTS (EXPECTED_PKTS != 0). Sticky until reset. Acceptance continues after it is set.
- Simultaneous events: a single beat can complete one packet and register one error, e.g. IN_PKT sop&eop gives err_no_eop and a good single-beat packet in the same cycle.

Decomposition:
- Package pkt_mon_pkg:
  - EMPTY_W function.
  - LFSR tap mask constant.
  - Default seed constant.
  - State enum {IDLE, IN_PKT}.
  - fold32 function (XOR-reduce DATA_WIDTH to 32 bits).
- Sub-module lfsr_ready_gen (SEED, READY_RATE; clk, reset, o_ready).
- Framing FSM, counters and signature stay in the top module.

Test Plan:
- READY_RATE 256; one 3-beat packet, empty 4 on EOP -> pkt_count 1, byte_count 188, last_len 188, no errors.
- Single-beat packet, empty 63, data MSB byte 0xAB, rest 0 -> byte_count 1, signature 32'hAB000000.
- Beat without SOP in IDLE, then a 2-beat packet (empty 0) -> err_no_sop 1, pkt_count 1, byte_count 128.
- 2 beats without EOP, then a new 1-beat packet with empty 0 -> err_no_eop 1, pkt_count 1, last_len 64.
- READY_RATE 64, SEED 1, EXPECTED_PKTS 10, always-valid source -> o_ready duty ≈ 25% over 4096 cycles; o_finished rises the cycle after the 10th EOP is accepted.
- Reset asserted mid-packet, then one good 1-beat packet -> all counters 0 after reset, pkt_count 1 after, error counters 0.
